// File: rtl/mul16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul16_pkg
//  Description : Shared constants for the shift-and-add 16x16 multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
package mul16_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int COUNT_W   = 5;

    localparam logic [COUNT_W-1:0] LAST_ITER = 5'd15;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage : mul16_pkg
`default_nettype wire

// File: rtl/shift_add_mul16_adder16.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mul16_adder16
//  Description : 16-bit ripple-carry adder (Adder16), time-shared by the
//                multiplier controller.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_add_mul16_adder16
    import mul16_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] InputA,
    input  logic [MUL_WIDTH-1:0] InputB,
    input  logic                 CarryIn,
    output logic [MUL_WIDTH-1:0] Sum,
    output logic                 CarryOut
);

    logic [MUL_WIDTH:0] w_carry;

    assign w_carry[0] = CarryIn;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_WIDTH; gi++) begin : g_ripple
            logic w_half;
            assign w_half          = InputA[gi] ^ InputB[gi];
            assign Sum[gi]         = w_half ^ w_carry[gi];
            assign w_carry[gi + 1] = (InputA[gi] & InputB[gi]) | (w_carry[gi] & w_half);
        end
    endgenerate

    assign CarryOut = w_carry[MUL_WIDTH];

endmodule : shift_add_mul16_adder16
`default_nettype wire

// File: rtl/shift_add_mul16.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mul16
//  Description : Sequential 16x16 unsigned shift-and-add multiplier over one
//                shared Adder16. Optional macro MUL_ZERO_BYPASS_EN skips the
//                iterations when either operand is zero.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_add_mul16
    import mul16_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic               Clk,
    input  logic               ResetN,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   InputA,
    input  logic [WIDTH-1:0]   InputB,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy
);

    logic [1:0]             r_state;
    logic [1:0]             w_nextState;
    logic [MUL_WIDTH-1:0]   r_mcand;
    logic [2*MUL_WIDTH-1:0] r_acc;
    logic [COUNT_W-1:0]     r_count;

    logic                   w_accept;
    logic                   w_zeroOp;
    logic [MUL_WIDTH-1:0]   w_addend;
    logic [MUL_WIDTH-1:0]   w_sum;
    logic                   w_carryOut;

    assign w_accept = InValid && InReady;

`ifdef MUL_ZERO_BYPASS_EN
    assign w_zeroOp = (InputA == '0) || (InputB == '0);
`else
    assign w_zeroOp = 1'b0;
`endif

    // Add the multiplicand only when the current multiplier LSB is set.
    assign w_addend = r_acc[0] ? r_mcand : '0;

    shift_add_mul16_adder16 u_adder16 (
        .InputA   (r_acc[2*MUL_WIDTH-1:MUL_WIDTH]),
        .InputB   (w_addend),
        .CarryIn  (1'b0),
        .Sum      (w_sum),
        .CarryOut (w_carryOut)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_zeroOp ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_count == LAST_ITER) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        InReady  = 1'b0;
        OutValid = 1'b0;
        Busy     = 1'b0;
        case (r_state)
            IDLE:    InReady = 1'b1;
            RUN:     Busy    = 1'b1;
            DONE: begin
                OutValid = 1'b1;
                Busy     = 1'b1;
            end
            default: InReady = 1'b0;
        endcase
    end

    // Datapath: the carry-out lands in Acc[31], so the product never overflows.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand <= InputA;
                        r_acc   <= w_zeroOp ? '0 : {{MUL_WIDTH{1'b0}}, InputB};
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= {w_carryOut, w_sum, r_acc[MUL_WIDTH-1:1]};
                    r_count <= r_count + COUNT_W'(1);
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign Product = r_acc;

endmodule : shift_add_mul16
`default_nettype wire

// File: tb/tb_shift_add_mul16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_mul16
//  Description : Scoreboard bench for shift_add_mul16 with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_add_mul16;

    typedef struct {
        logic [31:0] exp;
        int          acceptEdge;
        int          lat;
    } sbItem_t;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        InValid;
    logic        InReady;
    logic [15:0] InputA;
    logic [15:0] InputB;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Product;
    logic        Busy;

    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    sbItem_t sb[$];
    logic    prevValid = 1'b0;
    logic    idleNext = 1'b0;

`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 0;  // DONE is already visible right after the accept edge
`else
    localparam int ZERO_LAT = 16;
`endif

    shift_add_mul16 #(.WIDTH(16)) dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .InValid  (InValid),
        .InReady  (InReady),
        .InputA   (InputA),
        .InputB   (InputB),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Product  (Product),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Drive operands until accepted; record the accept edge number.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int lat, output int acc);
        int n = 0;
        acc = -1;
        InValid = 1'b1;
        InputA  = a;
        InputB  = b;
        while (!InReady && n < 200) begin
            step();
            n++;
        end
        if (!InReady) begin
            chk("acceptTimeout", {31'b0, InReady}, 32'd1);
        end else begin
            acc = cyc + 1;
            sb.push_back('{exp, acc, lat});
        end
        step();
        InValid = 1'b0;
        InputA  = 16'($urandom);
        InputB  = 16'($urandom);
    endtask

    task automatic waitValid();
        int n = 0;
        while (!OutValid && n < 40) begin
            step();
            n++;
        end
        if (!OutValid) chk("validTimeout", {31'b0, OutValid}, 32'd1);
    endtask

    // Monitor: every visible result is compared with the scoreboard head.
    always @(negedge Clk) begin
        if (!ResetN) begin
            prevValid = 1'b0;
            idleNext  = 1'b0;
        end else begin
            if (idleNext) begin
                chk("idleAfterDone", {30'b0, InReady, Busy}, 32'd2);
                idleNext = 1'b0;
            end
            if (OutValid) begin
                if (sb.size() == 0) begin
                    chk("spuriousValid", {31'b0, OutValid}, 32'd0);
                end else begin
                    if (!prevValid)
                        chk("latency", 32'(cyc - sb[0].acceptEdge), 32'(sb[0].lat));
                    chk("product", Product, sb[0].exp);
                    chk("inReadyInDone", {31'b0, InReady}, 32'd0);
                    if (OutReady) begin
                        void'(sb.pop_front());
                        idleNext = 1'b1;
                    end
                end
            end
            prevValid = OutValid;
        end
    end

    initial begin
        int acc;
        int n0;
        ResetN   = 1'b0;
        InValid  = 1'b0;
        InputA   = '0;
        InputB   = '0;
        OutReady = 1'b1;
        step();
        step();
        ResetN = 1'b1;
        chk("rstInReady",  {31'b0, InReady},  32'd1);
        chk("rstOutValid", {31'b0, OutValid}, 32'd0);
        chk("rstBusy",     {31'b0, Busy},     32'd0);
        chk("rstProduct",  Product,           32'h0);

        issue(16'h0003, 16'h0005, 32'h0000000F, 16, acc);
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, acc);
        issue(16'h8000, 16'h0002, 32'h00010000, 16, acc);
        issue(16'h00FF, 16'h0101, 32'h0000FFFF, 16, acc);

        // Backpressure with new operands waiting
        waitValid();
        step();
        step();
        OutReady = 1'b0;
        issue(16'h1234, 16'h0010, 32'h00012340, 16, acc);
        waitValid();
        InValid = 1'b1;
        InputA  = 16'h0002;
        InputB  = 16'h0003;
        repeat (10) begin
            chk("bpInReady", {31'b0, InReady}, 32'd0);
            step();
        end
        OutReady = 1'b1;
        n0 = cyc;
        issue(16'h0002, 16'h0003, 32'h00000006, 16, acc);
        chk("bpAcceptEdge", 32'(acc), 32'(n0 + 2));

        // Reset in the middle of an operation
        issue(16'h00FF, 16'h00FF, 32'h0000FE01, 16, acc);
        repeat (7) step();
        ResetN = 1'b0;
        step();
        ResetN = 1'b1;
        sb.delete();
        chk("midRstInReady",  {31'b0, InReady},  32'd1);
        chk("midRstOutValid", {31'b0, OutValid}, 32'd0);
        chk("midRstBusy",     {31'b0, Busy},     32'd0);
        chk("midRstProduct",  Product,           32'h0);
        repeat (20) step();
        issue(16'h0007, 16'h0009, 32'h0000003F, 16, acc);

        // Zero operands
        issue(16'h1234, 16'h0000, 32'h00000000, ZERO_LAT, acc);
        issue(16'h0000, 16'hABCD, 32'h00000000, ZERO_LAT, acc);
        issue(16'h0001, 16'h0001, 32'h00000001, 16, acc);

        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                step();
                n++;
            end
        end
        step();
        chk("scoreboardDrained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_add_mul16
`default_nettype wire
